// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one dual_ram between two writers and two readers.
// RAM controls are registered; read data is returned tagged to the winning reader.
module dual_ram_arbiter #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wreq0,
  input  logic             i_wreq1,
  input  logic [ADDR-1:0]  i_waddr0,
  input  logic [ADDR-1:0]  i_waddr1,
  input  logic [WIDTH-1:0] i_wdata0,
  input  logic [WIDTH-1:0] i_wdata1,
  output logic             o_wgnt0,
  output logic             o_wgnt1,
  input  logic             i_rreq0,
  input  logic             i_rreq1,
  input  logic [ADDR-1:0]  i_raddr0,
  input  logic [ADDR-1:0]  i_raddr1,
  output logic             o_rgnt0,
  output logic             o_rgnt1,
  output logic             o_rvalid0,
  output logic             o_rvalid1,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ram_write,
  output logic [ADDR-1:0]  o_ram_wr_addr,
  output logic [WIDTH-1:0] o_ram_data_in,
  output logic             o_ram_read,
  output logic [ADDR-1:0]  o_ram_rd_addr,
  input  logic [WIDTH-1:0] i_ram_data_out
);

  logic             w_wgnt0;
  logic             w_wgnt1;
  logic             w_wdone;
  logic             w_rgnt0;
  logic             w_rgnt1;
  logic             w_rdone;
  logic             w_collide;
  logic [WIDTH-1:0] w_rdata_mux;

  logic             r_wptr;
  logic             r_rptr;
  logic             r_ram_write;
  logic [ADDR-1:0]  r_ram_wr_addr;
  logic [WIDTH-1:0] r_ram_data_in;
  logic             r_ram_read;
  logic [ADDR-1:0]  r_ram_rd_addr;
  logic             r_tag;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic             r_fwd;
  logic [WIDTH-1:0] r_fwd_data;
  logic [WIDTH-1:0] r_rdata_hold;

  // Grants are held low during reset so no transfer can complete while it is asserted.
  assign w_wgnt0 = i_reset & i_wreq0 & (~i_wreq1 | ~r_wptr);
  assign w_wgnt1 = i_reset & i_wreq1 & (~i_wreq0 |  r_wptr);
  assign w_rgnt0 = i_reset & i_rreq0 & (~i_rreq1 | ~r_rptr);
  assign w_rgnt1 = i_reset & i_rreq1 & (~i_rreq0 |  r_rptr);

  assign w_wdone = w_wgnt0 | w_wgnt1;
  assign w_rdone = w_rgnt0 | w_rgnt1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_wgnt0)      r_wptr <= 1'b1;
      else if (w_wgnt1) r_wptr <= 1'b0;
      if (w_rgnt0)      r_rptr <= 1'b1;
      else if (w_rgnt1) r_rptr <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ram_write   <= 1'b0;
      r_ram_wr_addr <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_ram_write <= w_wdone;
      if (w_wdone) begin
        r_ram_wr_addr <= w_wgnt1 ? i_waddr1 : i_waddr0;
        r_ram_data_in <= w_wgnt1 ? i_wdata1 : i_wdata0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ram_read    <= 1'b0;
      r_ram_rd_addr <= '0;
      r_tag         <= 1'b0;
    end else begin
      r_ram_read <= w_rdone;
      if (w_rdone) begin
        r_ram_rd_addr <= w_rgnt1 ? i_raddr1 : i_raddr0;
        r_tag         <= w_rgnt1;
      end
    end
  end

  // The RAM returns old contents on a same-address read/write, so the write data is replayed.
  assign w_collide = r_ram_write & r_ram_read & (r_ram_wr_addr == r_ram_rd_addr);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_fwd        <= 1'b0;
      r_fwd_data   <= '0;
      r_rdata_hold <= '0;
    end else begin
      r_rvalid0    <= r_ram_read & ~r_tag;
      r_rvalid1    <= r_ram_read &  r_tag;
      r_fwd        <= w_collide;
      r_fwd_data   <= r_ram_data_in;
      r_rdata_hold <= o_rdata;
    end
  end

  assign w_rdata_mux = r_fwd ? r_fwd_data : i_ram_data_out;

  assign o_rdata       = (r_rvalid0 | r_rvalid1) ? w_rdata_mux : r_rdata_hold;
  assign o_wgnt0       = w_wgnt0;
  assign o_wgnt1       = w_wgnt1;
  assign o_rgnt0       = w_rgnt0;
  assign o_rgnt1       = w_rgnt1;
  assign o_rvalid0     = r_rvalid0;
  assign o_rvalid1     = r_rvalid1;
  assign o_ram_write   = r_ram_write;
  assign o_ram_wr_addr = r_ram_wr_addr;
  assign o_ram_data_in = r_ram_data_in;
  assign o_ram_read    = r_ram_read;
  assign o_ram_rd_addr = r_ram_rd_addr;

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Bench for dual_ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (memory array + queue of expected read returns) and a RAM model.
module tb_dual_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wreq0 = 1'b0, wreq1 = 1'b0, rreq0 = 1'b0, rreq1 = 1'b0;
  logic [3:0] waddr0 = '0, waddr1 = '0, raddr0 = '0, raddr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       wgnt0, wgnt1, rgnt0, rgnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       ramWrite, ramRead;
  logic [3:0] ramWrAddr, ramRdAddr;
  logic [7:0] ramDataIn;
  logic [7:0] ramDataOut = '0;
  logic [7:0] ramMem [16];
  logic       ramInitDone = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] data;
  } rdExp_t;

  rdExp_t     rq[$];
  logic [7:0] mMem [16];
  logic       mpW = 0, mpR = 0;
  logic       eWg0 = 0, eWg1 = 0, eRg0 = 0, eRg1 = 0, eRv0 = 0, eRv1 = 0;
  logic       eRamWrite = 0, eRamRead = 0, nRamWrite = 0, nRamRead = 0;
  logic [3:0] eWaddr = 0, eRaddr = 0, nWaddr = 0, nRaddr = 0;
  logic [7:0] eWdata = 0, nWdata = 0, eRdata = 0;

  dual_ram_arbiter #(.WIDTH(8), .ADDR(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_wreq0(wreq0), .i_wreq1(wreq1), .i_waddr0(waddr0), .i_waddr1(waddr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_wgnt0(wgnt0), .o_wgnt1(wgnt1),
    .i_rreq0(rreq0), .i_rreq1(rreq1), .i_raddr0(raddr0), .i_raddr1(raddr1),
    .o_rgnt0(rgnt0), .o_rgnt1(rgnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata(rdata), .o_ram_write(ramWrite), .o_ram_wr_addr(ramWrAddr),
    .o_ram_data_in(ramDataIn), .o_ram_read(ramRead), .o_ram_rd_addr(ramRdAddr),
    .i_ram_data_out(ramDataOut)
  );

  always #5 clk = ~clk;

  // dual_ram stand-in: registered read of the old contents, write at the same edge.
  always @(posedge clk) begin
    if (!ramInitDone) begin
      for (int i = 0; i < 16; i++) ramMem[i] <= 8'h00;
      ramInitDone <= 1'b1;
    end else begin
      if (ramRead)  ramDataOut <= ramMem[ramRdAddr];
      if (ramWrite) ramMem[ramWrAddr] <= ramDataIn;
    end
  end

  // Transaction model: writes are visible to reads granted in the same or later cycles.
  task automatic modelStep();
    cyc++;
    if (cyc == 1) for (int i = 0; i < 16; i++) mMem[i] = 8'h00;
    if (!reset) begin
      mpW = 0; mpR = 0; eWg0 = 0; eWg1 = 0; eRg0 = 0; eRg1 = 0; eRv0 = 0; eRv1 = 0;
      eRamWrite = 0; eRamRead = 0; nRamWrite = 0; nRamRead = 0;
      eWaddr = 0; eRaddr = 0; nWaddr = 0; nRaddr = 0; eWdata = 0; nWdata = 0; eRdata = 0;
      rq.delete();
    end else begin
      eRamWrite = nRamWrite; eWaddr = nWaddr; eWdata = nWdata;
      eRamRead = nRamRead; eRaddr = nRaddr;
      eRv0 = 0; eRv1 = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        eRv0 = !rq[0].id; eRv1 = rq[0].id; eRdata = rq[0].data;
        void'(rq.pop_front());
      end
      eWg0 = wreq0 && (!wreq1 || !mpW);
      eWg1 = wreq1 && (!wreq0 || mpW);
      eRg0 = rreq0 && (!rreq1 || !mpR);
      eRg1 = rreq1 && (!rreq0 || mpR);
      nRamWrite = eWg0 || eWg1;
      if (eWg0)      begin nWaddr = waddr0; nWdata = wdata0; mpW = 1; end
      else if (eWg1) begin nWaddr = waddr1; nWdata = wdata1; mpW = 0; end
      if (nRamWrite) mMem[nWaddr] = nWdata;
      nRamRead = eRg0 || eRg1;
      if (eRg0) begin
        nRaddr = raddr0; mpR = 1;
        rq.push_back('{due: cyc + 2, id: 1'b0, data: mMem[raddr0]});
      end else if (eRg1) begin
        nRaddr = raddr1; mpR = 0;
        rq.push_back('{due: cyc + 2, id: 1'b1, data: mMem[raddr1]});
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    modelStep();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    wreq0 = 1; wreq1 = 1; waddr0 = 4'd9; wdata0 = 8'h99; waddr1 = 4'd10; wdata1 = 8'hAA;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if ({wgnt0, wgnt1, rgnt0, rgnt1} !== 4'b0000) begin errors++; $display("FAIL rst_gnts got=%b exp=0000", {wgnt0, wgnt1, rgnt0, rgnt1}); end
      checks++; if ({ramWrite, ramRead, rvalid0, rvalid1} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {ramWrite, ramRead, rvalid0, rvalid1}); end
      checks++; if ({ramWrAddr, ramRdAddr, ramDataIn, rdata} !== 24'h0) begin errors++; $display("FAIL rst_data got=%h exp=000000", {ramWrAddr, ramRdAddr, ramDataIn, rdata}); end
      tick();
    end
    reset = 1;
    settle();
    checks++; if ({wgnt0, wgnt1} !== 2'b10) begin errors++; $display("FAIL first_wgnt got=%b exp=10", {wgnt0, wgnt1}); end
    tick();
    wreq0 = 0; wreq1 = 0;
    settle();
    checks++; if ({ramWrite, ramWrAddr, ramDataIn} !== {1'b1, 4'd9, 8'h99}) begin errors++; $display("FAIL first_wr got=%h exp=%h", {ramWrite, ramWrAddr, ramDataIn}, {1'b1, 4'd9, 8'h99}); end
    tick();
  endtask

  task automatic test_write_then_read();
    wreq0 = 1; waddr0 = 4'd3; wdata0 = 8'hA5;
    settle();
    checks++; if ({wgnt0, wgnt1} !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", {wgnt0, wgnt1}); end
    tick(); wreq0 = 0;
    settle();
    checks++; if ({ramWrite, ramWrAddr, ramDataIn} !== {1'b1, 4'd3, 8'hA5}) begin errors++; $display("FAIL wr_issue got=%h exp=%h", {ramWrite, ramWrAddr, ramDataIn}, {1'b1, 4'd3, 8'hA5}); end
    tick();
    settle();
    checks++; if ({ramWrite, ramWrAddr, ramDataIn} !== {1'b0, 4'd3, 8'hA5}) begin errors++; $display("FAIL wr_hold got=%h exp=%h", {ramWrite, ramWrAddr, ramDataIn}, {1'b0, 4'd3, 8'hA5}); end
    tick();
    rreq1 = 1; raddr1 = 4'd3;
    settle();
    checks++; if ({rgnt0, rgnt1} !== 2'b01) begin errors++; $display("FAIL rd_gnt got=%b exp=01", {rgnt0, rgnt1}); end
    tick(); rreq1 = 0;
    settle();
    checks++; if ({ramRead, ramRdAddr, rvalid0, rvalid1} !== {1'b1, 4'd3, 2'b00}) begin errors++; $display("FAIL rd_issue got=%b exp=%b", {ramRead, ramRdAddr, rvalid0, rvalid1}, {1'b1, 4'd3, 2'b00}); end
    tick();
    settle();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 8'hA5}) begin errors++; $display("FAIL rd_return got=%h exp=%h", {rvalid0, rvalid1, rdata}, {2'b01, 8'hA5}); end
    tick();
    settle();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b00, 8'hA5}) begin errors++; $display("FAIL rd_hold got=%h exp=%h", {rvalid0, rvalid1, rdata}, {2'b00, 8'hA5}); end
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] expAddr;
    wreq1 = 1; waddr1 = 4'd0; wdata1 = 8'h10;
    settle();
    checks++; if ({wgnt0, wgnt1} !== 2'b01) begin errors++; $display("FAIL solo_wgnt1 got=%b exp=01", {wgnt0, wgnt1}); end
    tick();
    wreq0 = 1; waddr0 = 4'd6; wdata0 = 8'h66; waddr1 = 4'd7; wdata1 = 8'h77;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if ({wgnt0, wgnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_gnt%0d got=%b", k, {wgnt0, wgnt1}); end
      if (k > 0) begin
        expAddr = ((k - 1) % 2 == 0) ? 4'd6 : 4'd7;
        checks++; if ({ramWrite, ramWrAddr} !== {1'b1, expAddr}) begin errors++; $display("FAIL alt_addr%0d got=%h exp=%h", k, {ramWrite, ramWrAddr}, {1'b1, expAddr}); end
      end
      tick();
    end
    wreq0 = 0; wreq1 = 0;
    settle();
    checks++; if ({ramWrite, ramWrAddr, ramDataIn} !== {1'b1, 4'd7, 8'h77}) begin errors++; $display("FAIL alt_last got=%h exp=%h", {ramWrite, ramWrAddr, ramDataIn}, {1'b1, 4'd7, 8'h77}); end
    tick();
  endtask

  task automatic test_collision();
    wreq0 = 1; waddr0 = 4'd5; wdata0 = 8'h11;
    tick(); wreq0 = 0;
    tick(); tick();
    wreq0 = 1; wdata0 = 8'h3C; rreq1 = 1; raddr1 = 4'd5;
    settle();
    checks++; if ({wgnt0, rgnt1} !== 2'b11) begin errors++; $display("FAIL col_gnts got=%b exp=11", {wgnt0, rgnt1}); end
    tick(); wreq0 = 0; rreq1 = 0;
    settle();
    checks++; if ({ramWrite, ramRead, ramWrAddr, ramRdAddr} !== {2'b11, 4'd5, 4'd5}) begin errors++; $display("FAIL col_issue got=%h", {ramWrite, ramRead, ramWrAddr, ramRdAddr}); end
    tick();
    settle();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 8'h3C}) begin errors++; $display("FAIL col_fwd got=%h exp=%h", {rvalid0, rvalid1, rdata}, {2'b01, 8'h3C}); end
    tick();
  endtask

  task automatic test_tag_order();
    wreq0 = 1; waddr0 = 4'd1; wdata0 = 8'h01;
    tick(); waddr0 = 4'd2; wdata0 = 8'h02;
    tick(); wreq0 = 0;
    tick();
    rreq0 = 1; raddr0 = 4'd1; rreq1 = 1; raddr1 = 4'd2;
    settle();
    checks++; if ({rgnt0, rgnt1} !== 2'b10) begin errors++; $display("FAIL tag_gnt0 got=%b exp=10", {rgnt0, rgnt1}); end
    tick(); rreq0 = 0;
    settle();
    checks++; if ({rgnt0, rgnt1} !== 2'b01) begin errors++; $display("FAIL tag_gnt1 got=%b exp=01", {rgnt0, rgnt1}); end
    tick(); rreq1 = 0;
    settle();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h01}) begin errors++; $display("FAIL tag_ret0 got=%h exp=%h", {rvalid0, rvalid1, rdata}, {2'b10, 8'h01}); end
    tick();
    settle();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 8'h02}) begin errors++; $display("FAIL tag_ret1 got=%h exp=%h", {rvalid0, rvalid1, rdata}, {2'b01, 8'h02}); end
    tick();
  endtask

  task automatic test_reset_during_read();
    tick();
    rreq0 = 1; raddr0 = 4'd4;
    settle();
    checks++; if (rgnt0 !== 1'b1) begin errors++; $display("FAIL rdrst_gnt got=%b exp=1", rgnt0); end
    tick(); rreq0 = 0; reset = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if ({ramRead, rvalid0, rvalid1} !== 3'b000) begin errors++; $display("FAIL rdrst_hold%0d got=%b exp=000", k, {ramRead, rvalid0, rvalid1}); end
      tick();
    end
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rdrst_after%0d got=%b exp=00", k, {rvalid0, rvalid1}); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      settle();
      checks++; if ({wgnt0, wgnt1, rgnt0, rgnt1} !== {eWg0, eWg1, eRg0, eRg1}) begin errors++; $display("FAIL rnd_gnts c%0d got=%b exp=%b", k, {wgnt0, wgnt1, rgnt0, rgnt1}, {eWg0, eWg1, eRg0, eRg1}); end
      checks++; if ({ramWrite, ramWrAddr, ramDataIn} !== {eRamWrite, eWaddr, eWdata}) begin errors++; $display("FAIL rnd_wr c%0d got=%h exp=%h", k, {ramWrite, ramWrAddr, ramDataIn}, {eRamWrite, eWaddr, eWdata}); end
      checks++; if ({ramRead, ramRdAddr} !== {eRamRead, eRaddr}) begin errors++; $display("FAIL rnd_rd c%0d got=%h exp=%h", k, {ramRead, ramRdAddr}, {eRamRead, eRaddr}); end
      checks++; if ({rvalid0, rvalid1, rdata} !== {eRv0, eRv1, eRdata}) begin errors++; $display("FAIL rnd_ret c%0d got=%h exp=%h", k, {rvalid0, rvalid1, rdata}, {eRv0, eRv1, eRdata}); end
      tick();
      if (!wreq0 || eWg0) begin wreq0 = 1'($urandom_range(0, 1)); waddr0 = 4'($urandom_range(0, 3)); wdata0 = 8'($urandom); end
      else if ($urandom_range(0, 7) == 0) wreq0 = 0;
      if (!wreq1 || eWg1) begin wreq1 = 1'($urandom_range(0, 1)); waddr1 = 4'($urandom_range(0, 3)); wdata1 = 8'($urandom); end
      else if ($urandom_range(0, 7) == 0) wreq1 = 0;
      if (!rreq0 || eRg0) begin rreq0 = 1'($urandom_range(0, 1)); raddr0 = 4'($urandom_range(0, 3)); end
      else if ($urandom_range(0, 7) == 0) rreq0 = 0;
      if (!rreq1 || eRg1) begin rreq1 = 1'($urandom_range(0, 1)); raddr1 = 4'($urandom_range(0, 3)); end
      else if ($urandom_range(0, 7) == 0) rreq1 = 0;
    end
    wreq0 = 0; wreq1 = 0; rreq0 = 0; rreq1 = 0;
    tick(); tick(); tick();
  endtask

  initial begin
    #1 reset = 0;
    test_reset();
    test_write_then_read();
    test_contention();
    test_collision();
    test_tag_order();
    test_reset_during_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_ram_arbiter.md
# dual_ram_arbiter

Two-requester round-robin arbiter and sequencer for the 16x8 dual-port RAM (`dual_ram`). It shares the RAM write port between two writers and the read port between two readers with req/gnt handshakes. It registers all RAM-side controls and returns read data tagged to the winning reader. It also forwards write data when a read and a write hit the same address in the same RAM cycle. It sits between the requesting blocks and a `dual_ram` instance. The RAM is not instantiated inside.

## Interface
- WIDTH, 8, data width
- ADDR, 4, address width (RAM depth 2**ADDR = 16)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wreq0 / wreq1  in  1  write request, requester 0 / 1
- waddr0 / waddr1  in  ADDR  write address
- wdata0 / wdata1  in  WIDTH  write data
- wgnt0 / wgnt1  out  1  write grant, combinational
- rreq0 / rreq1  in  1  read request, requester 0 / 1
- raddr0 / raddr1  in  ADDR  read address
- rgnt0 / rgnt1  out  1  read grant, combinational
- rvalid0 / rvalid1  out  1  read data valid for requester 0 / 1, registered
- rdata  out  WIDTH  read return data, shared by both readers
- ram_write  out  1  to RAM `write`, registered
- ram_wr_addr  out  ADDR  to RAM `wr_addr`, registered
- ram_data_in  out  WIDTH  to RAM `data_in`, registered
- ram_read  out  1  to RAM `read`, registered
- ram_rd_addr  out  ADDR  to RAM `rd_addr`, registered
- ram_data_out  in  WIDTH  from RAM `data_out`; valid the cycle after the RAM samples `read`

## Operation
- Write port and read port are arbitrated independently. Each has a 1-bit priority pointer `wptr` and `rptr`; 0 means requester 0 has priority.
- Grant rules, per port:
  - Only one requester active: that requester is granted.
  - Both active: the pointer holder is granted.
  - Neither active: no grant.
  - Grants are one-hot or zero. They never depend on the other port.
- A transfer completes when req && gnt are both high at a rising edge.
  - On completion, the pointer moves to the other requester.
  - With no completion, the pointer holds.
- Requesters must hold addr and data stable while req is high. Dropping req before grant is legal; nothing is issued.
- RAM-side issue: on a completed write, the next edge loads ram_write=1 and the granted ram_wr_addr / ram_data_in. Otherwise ram_write=0, and addr/data hold their previous value.
- Read issue works the same way on ram_read / ram_rd_addr. A 1-bit tag register stores the granted reader ID.
- Read return:
  - One cycle after ram_read=1, exactly one of rvalid0/rvalid1 goes high for one cycle, chosen by the delayed tag.
  - rdata is taken from the read-data mux. rdata holds its last value when no rvalid is high.
- Collision forwarding:
  - Condition: ram_write && ram_read && ram_wr_addr == ram_rd_addr in the same cycle.
  - A 1-cycle forward flag and a copy of ram_data_in are registered.
  - rdata returns that write data instead of ram_data_out, i.e. write-first semantics.
- Back-to-back completions on every cycle are supported on both ports. Throughput is 1 write plus 1 read per cycle.

## Timing
- Reset asserted (reset=0), asynchronously:
  - wptr=rptr=0.
  - ram_write=ram_read=0; ram_wr_addr=ram_rd_addr=0; ram_data_in=0.
  - rvalid0=rvalid1=0; rdata=0; tag and forward flag cleared.
- Reset mid-operation: in-flight reads are discarded. No rvalid may assert from a read issued before reset.
- Write latency: grant in cycle N, RAM controls valid in N+1, RAM array updated at the end of N+1.
- Read latency: grant in cycle N, ram_read in N+1, rvalidX and rdata in N+2. Fixed at 2 cycles.
- Grants are combinational from req and the pointer. No combinational path exists from ram_data_out to any grant.

## Test plan
- Reset: hold reset=0 for 2 cycles with both wreq high, then release.
  - All outputs are 0 during reset.
  - The first grant is wgnt0.
- Single writer, then single reader:
  - wreq0 waddr0=3 wdata0=8'hA5 → ram_write=1, addr 3, data A5 one cycle later.
  - A later rreq1 raddr1=3 → rvalid1=1 with rdata=A5 exactly 2 cycles after rgnt1.
- Contention: wreq0 and wreq1 both held for 4 cycles → grants alternate 0,1,0,1, and the RAM writes addresses in that order.
- Collision: write addr 5 data 8'h3C and read addr 5 granted in the same cycle, with old contents 8'h11 → rdata=3C, not 11.
- Read tag ordering: rreq0 raddr 1 and rreq1 raddr 2 both held, with mem[1]=8'h01 and mem[2]=8'h02 → rvalid0/01, then rvalid1/02 on consecutive cycles.
- Reset during read: assert reset one cycle after rgnt0 → no rvalid0 ever appears after release.
